// File: rtl/id_ex_pipe_reg.sv
// ID/EX stage register: captures decoded control/operands into EX, picks the destination reg, inserts load-use and redirect bubbles.
// Latency: one core clock from id_* inputs to ex_* outputs.
// Backpressure: hold freezes the stage and stalls the front end; load-use stalls the front end and injects a bubble.
module id_ex_pipe_reg #(
    parameter int CTRL_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              ex_redirect,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_pc4,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_pc4,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wreg,
    output logic [4:0]        ex_shamt,
    output logic              stall_front,
    output logic              flush_if_id,
    output logic [CNT_W-1:0]  bubble_count
);

    // Control bundle bit positions used inside this stage
    localparam int REGWRITE = 19;
    localparam int REGDST   = 13;
    localparam int MEMTOREG = 12;
    localparam int JAL      = 3;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc4;
        logic [31:0]       rs_data;
        logic [31:0]       rt_data;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        wreg;
        logic [4:0]        shamt;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t ex_d;
    logic [4:0] id_wreg;
    logic       load_use;

    // Destination register: jal links to $31, R-type writes rd, everything else rt
    always_comb begin
        id_wreg = id_rt;
        if (id_ctrl[JAL]) begin
            id_wreg = 5'd31;
        end else if (id_ctrl[REGDST]) begin
            id_wreg = id_rd;
        end
    end

    // A load in EX whose result the ID instruction needs; $0 never creates a dependency
    always_comb begin
        load_use = ex_q.valid && ex_q.ctrl[MEMTOREG] && ex_q.ctrl[REGWRITE] &&
                   (ex_q.wreg != 5'd0) && id_valid &&
                   ((id_use_rs && (ex_q.wreg == id_rs)) ||
                    (id_use_rt && (ex_q.wreg == id_rt)));
    end

    // Front-end controls: hold beats redirect beats load-use, so the two are mutually exclusive
    always_comb begin
        stall_front = 1'b0;
        flush_if_id = 1'b0;
        if (hold) begin
            stall_front = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
        end else if (load_use) begin
            stall_front = 1'b1;
        end
    end

    // Next EX contents: a real capture, or an all-zero bubble for redirect, load-use or empty ID
    always_comb begin
        ex_d = '0;
        if (!ex_redirect && !load_use && id_valid) begin
            ex_d.valid   = 1'b1;
            ex_d.ctrl    = id_ctrl;
            ex_d.pc4     = id_pc4;
            ex_d.rs_data = id_rs_data;
            ex_d.rt_data = id_rt_data;
            ex_d.imm     = id_imm;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.wreg    = id_wreg;
            ex_d.shamt   = id_shamt;
        end
    end

    // Stage register; hold freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (!hold) begin
            ex_q <= ex_d;
        end
    end

    // Saturating count of load-use bubbles actually inserted (not those masked by hold/redirect)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= '0;
        end else if (!hold && !ex_redirect && load_use && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_ctrl    = ex_q.ctrl;
    assign ex_pc4     = ex_q.pc4;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm     = ex_q.imm;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_wreg    = ex_q.wreg;
    assign ex_shamt   = ex_q.shamt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed pipeline scenarios followed by randomized traffic.
// Expected EX contents and front-end controls come from a cycle-level reference model.
// A monitor process pops expectations and compares against the DUT each cycle.
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        ex_redirect;
    logic        id_valid;
    logic [19:0] id_ctrl;
    logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        id_use_rs, id_use_rt;
    logic        ex_valid;
    logic [19:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg, ex_shamt;
    logic        stall_front, flush_if_id;
    logic [15:0] bubble_count;

    id_ex_pipe_reg #(.CTRL_W(20), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .ex_redirect(ex_redirect),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_shamt(ex_shamt),
        .stall_front(stall_front), .flush_if_id(flush_if_id),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        redirect;
        logic        valid;
        logic [19:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        use_rs, use_rt;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [19:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, wreg, shamt;
    } ex_model_t;

    typedef struct {
        logic        stall;
        logic        flush;
        ex_model_t   st;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [19:0] C_RW  = 20'h80000;  // regwrite
    localparam logic [19:0] C_SRC = 20'h04000;  // alusrc
    localparam logic [19:0] C_DST = 20'h02000;  // regdst
    localparam logic [19:0] C_M2R = 20'h01000;  // memtoreg
    localparam logic [19:0] C_JAL = 20'h00008;  // jal

    exp_t      exp_q[$];
    ex_model_t m;
    ex_model_t bubble_st;
    logic [15:0] m_cnt;
    int n_pass  = 0;
    int n_total = 0;
    bit done    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    task automatic apply(input stim_t s);
        hold = s.hold; ex_redirect = s.redirect; id_valid = s.valid; id_ctrl = s.ctrl;
        id_pc4 = s.pc4; id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_shamt = s.shamt;
        id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    endtask

    function automatic stim_t mk(input logic [19:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic use_rs, input logic use_rt);
        stim_t s;
        s.hold = 0; s.redirect = 0; s.valid = 1; s.ctrl = ctrl;
        s.pc4 = $urandom; s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
        s.rs = rs; s.rt = rt; s.rd = rd; s.shamt = 5'($urandom);
        s.use_rs = use_rs; s.use_rt = use_rt;
        return s;
    endfunction

    // Reference model: one instruction slot in EX, rules applied in priority order
    task automatic cycle(input stim_t s);
        exp_t e;
        bit needs_ex;
        @(negedge clk);
        apply(s);
        needs_ex = (s.use_rs && s.rs == m.wreg) || (s.use_rt && s.rt == m.wreg);
        e.stall = 0; e.flush = 0; e.st = m; e.cnt = m_cnt;
        if (s.hold) begin
            e.stall = 1;
        end else if (s.redirect) begin
            e.flush = 1; e.st = bubble_st;
        end else if (s.valid && m.valid && m.ctrl[12] && m.ctrl[19] && m.wreg != 0 && needs_ex) begin
            e.stall = 1; e.st = bubble_st;
            if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
        end else if (!s.valid) begin
            e.st = bubble_st;
        end else begin
            e.st.valid = 1; e.st.ctrl = s.ctrl; e.st.pc4 = s.pc4; e.st.rsd = s.rsd;
            e.st.rtd = s.rtd; e.st.imm = s.imm; e.st.rs = s.rs; e.st.rt = s.rt;
            e.st.shamt = s.shamt;
            e.st.wreg = s.ctrl[3] ? 5'd31 : (s.ctrl[13] ? s.rd : s.rt);
        end
        exp_q.push_back(e);
        m = e.st; m_cnt = e.cnt;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = mk(20'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        s.valid = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 2) == 0) s.ctrl = s.ctrl | C_RW | C_M2R;
        if (m.valid && $urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) s.rs = m.wreg; else s.rt = m.wreg;
        end
        s.hold     = ($urandom_range(0, 9) == 0);
        s.redirect = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // Monitor: front-end controls mid-cycle, EX registers just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stall_front", 32'(stall_front), 32'(e.stall));
                chk("flush_if_id", 32'(flush_if_id), 32'(e.flush));
                @(posedge clk);
                #1;
                chk("ex_valid",   32'(ex_valid),   32'(e.st.valid));
                chk("ex_ctrl",    32'(ex_ctrl),    32'(e.st.ctrl));
                chk("ex_pc4",     ex_pc4,          e.st.pc4);
                chk("ex_rs_data", ex_rs_data,      e.st.rsd);
                chk("ex_rt_data", ex_rt_data,      e.st.rtd);
                chk("ex_imm",     ex_imm,          e.st.imm);
                chk("ex_rs",      32'(ex_rs),      32'(e.st.rs));
                chk("ex_rt",      32'(ex_rt),      32'(e.st.rt));
                chk("ex_wreg",    32'(ex_wreg),    32'(e.st.wreg));
                chk("ex_shamt",   32'(ex_shamt),   32'(e.st.shamt));
                chk("bubble_count", 32'(bubble_count), 32'(e.cnt));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ex_ctrl"},  32'(ex_ctrl),  32'd0);
        chk({tag, "_ex_pc4"},   ex_pc4,        32'd0);
        chk({tag, "_ex_rs_data"}, ex_rs_data,  32'd0);
        chk({tag, "_ex_rt_data"}, ex_rt_data,  32'd0);
        chk({tag, "_ex_imm"},   ex_imm,        32'd0);
        chk({tag, "_ex_wreg"},  32'(ex_wreg),  32'd0);
        chk({tag, "_ex_rs"},    32'(ex_rs),    32'd0);
        chk({tag, "_ex_shamt"}, 32'(ex_shamt), 32'd0);
        chk({tag, "_bubble_count"}, 32'(bubble_count), 32'd0);
        chk({tag, "_stall_front"},  32'(stall_front),  32'd0);
    endtask

    // Stimulus
    initial begin
        stim_t s;
        stim_t lw9;
        bubble_st = '{valid: 0, ctrl: '0, pc4: '0, rsd: '0, rtd: '0, imm: '0,
                      rs: '0, rt: '0, wreg: '0, shamt: '0};
        m = bubble_st; m_cnt = 16'd0;
        s = mk(20'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        s.valid = 0;
        rst_n = 1'b0;
        apply(s);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        lw9 = mk(C_RW | C_M2R | C_SRC, 5'd4, 5'd9, 5'd0, 1, 0);

        // ADDU $8, then JAL (rd=5, rt=7) and ORI into $7
        cycle(mk(C_RW | C_DST, 5'd2, 5'd3, 5'd8, 1, 1));
        cycle(mk(C_RW | C_JAL | C_DST, 5'd0, 5'd7, 5'd5, 0, 0));
        cycle(mk(C_RW | C_SRC, 5'd1, 5'd7, 5'd12, 1, 0));

        // Load-use on rs, then the same pair without rs use
        cycle(lw9);
        cycle(mk(C_RW | C_DST, 5'd9, 5'd3, 5'd10, 1, 1));
        cycle(lw9);
        cycle(mk(C_RW | C_DST, 5'd9, 5'd3, 5'd10, 0, 1));
        cycle(lw9);
        cycle(mk(C_RW | C_SRC, 5'd1, 5'd9, 5'd0, 0, 1));

        // Load into $0 never stalls
        cycle(mk(C_RW | C_M2R | C_SRC, 5'd4, 5'd0, 5'd0, 1, 0));
        cycle(mk(C_RW | C_DST, 5'd0, 5'd0, 5'd11, 1, 1));

        // Redirect overrides load-use; hold overrides both
        cycle(lw9);
        s = mk(C_RW | C_DST, 5'd9, 5'd3, 5'd10, 1, 0);
        s.redirect = 1;
        cycle(s);
        cycle(lw9);
        s.hold = 1;
        cycle(s);
        cycle(s);
        s.hold = 0; s.redirect = 0;
        cycle(s);

        // Saturation: preset counter near the top, then three more load-use bubbles
        @(posedge clk);
        #3;
        force dut.bubble_count = 16'hFFFE;
        #1;
        release dut.bubble_count;
        m_cnt = 16'hFFFE;
        s.redirect = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(lw9);
            cycle(s);
        end
        cycle(lw9);

        // Asynchronous reset in the middle of a load-use stall
        @(negedge clk);
        apply(s);
        #3;
        chk("midstall_stall_front", 32'(stall_front), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk("reset_held_ex_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m = bubble_st; m_cnt = 16'd0;
        cycle(s);

        // Randomized traffic
        for (int i = 0; i < 600; i++) cycle(rand_stim());

        s.hold = 0; s.redirect = 0; s.valid = 0;
        cycle(s);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        if (!done) begin
            n_total++;
            $display("FAIL watchdog: run still active at %0t, expected completion", $time);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

endmodule
